// File: rtl/jtframe_db15_resp_if.sv
// Purpose : DB15 SNAC link bundle between a reader (master) and the responder (slave).
// Latency : n/a (signal bundle only).
// Backpr. : none; the reader paces the link through joy_clk/joy_load.
// Ports   : joy_clk/joy_load/p1/p2 flow master->slave;
//           joy_data/frame_done/bit_cnt/overrun/timeout flow slave->master.
interface jtframe_db15_resp_if #(
    parameter int BITS = 24
);
    logic                joy_clk;
    logic                joy_load;
    logic [BITS/2-1:0]   p1;
    logic [BITS/2-1:0]   p2;
    logic                joy_data;
    logic                frame_done;
    logic [4:0]          bit_cnt;
    logic                overrun;
    logic                timeout;

    modport master (
        output joy_clk, joy_load, p1, p2,
        input  joy_data, frame_done, bit_cnt, overrun, timeout
    );

    modport slave (
        input  joy_clk, joy_load, p1, p2,
        output joy_data, frame_done, bit_cnt, overrun, timeout
    );
endinterface

// File: rtl/jtframe_db15_resp.sv
// Purpose : DB15 SNAC responder; 74HC165-style shift chain for two players' buttons.
// Latency : pin (joy_clk/joy_load) to joy_data is 3+FILT clk cycles.
// Backpr. : none; shifts follow reader edges, extra edges after a frame shift 1s and flag overrun.
// Ports   : clk_i, rst_n_i (synchronous, active low); bus = slave side of jtframe_db15_resp_if.
module jtframe_db15_resp #(
    parameter int BITS = 24,
    parameter int FILT = 2,
    parameter int TOUT = 4096
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    jtframe_db15_resp_if.slave         bus
);
    localparam int FW = (FILT > 1) ? $clog2(FILT) : 1;
    localparam int TW = (TOUT > 1) ? $clog2(TOUT + 1) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOADED = 2'd1;
    localparam logic [1:0] ST_SHIFT  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Line index 0 = joy_clk, 1 = joy_load.
    logic [1:0]    s1_q, s2_q, flt_q, prev_q;
    logic [FW-1:0] fcnt_q [2];
    logic [1:0]    flt;

    // FILT==0 bypasses the filter so the edge detector sits right after the synchroniser.
    assign flt = (FILT == 0) ? s2_q : flt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s1_q      <= 2'b11;
            s2_q      <= 2'b11;
            flt_q     <= 2'b11;
            prev_q    <= 2'b11;
            fcnt_q[0] <= '0;
            fcnt_q[1] <= '0;
        end else begin
            s1_q   <= {bus.joy_load, bus.joy_clk};
            s2_q   <= s1_q;
            prev_q <= flt;
            // Filtered value follows only after FILT consecutive cycles of a differing input.
            for (int i = 0; i < 2; i++) begin
                if (s2_q[i] == flt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FW'(FILT - 1)) begin
                    flt_q[i]  <= s2_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    logic clk_rise, clk_any, load_rise, load_low;
    assign clk_rise  = flt[0] & ~prev_q[0];
    assign clk_any   = flt[0] ^ prev_q[0];
    assign load_rise = flt[1] & ~prev_q[1];
    assign load_low  = ~flt[1];

    logic [1:0]      state_q, state_d;
    logic [BITS-1:0] sr_q, sr_d;
    logic [4:0]      bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]   idle_q, idle_d;
    logic            frame_done_q, frame_done_d;
    logic            overrun_q, overrun_d;
    logic            timeout_q, timeout_d;

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        bit_cnt_d    = bit_cnt_q;
        idle_d       = idle_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;
        timeout_d    = timeout_q;

        if (load_low) begin
            // Transparent load: buttons keep being sampled and any joy_clk edge loses.
            sr_d      = ~{bus.p2, bus.p1};
            bit_cnt_d = '0;
            overrun_d = 1'b0;
            timeout_d = 1'b0;
            idle_d    = '0;
            state_d   = ST_LOADED;
        end else begin
            case (state_q)
                ST_LOADED: begin
                    // The load-release cycle never shifts, even if joy_clk rises with it.
                    if (load_rise) begin
                        state_d = ST_SHIFT;
                        idle_d  = '0;
                    end
                end
                ST_SHIFT: begin
                    if (clk_rise) begin
                        sr_d      = {sr_q[BITS-2:0], 1'b1};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_d == 5'(BITS)) begin
                            state_d      = ST_DONE;
                            frame_done_d = 1'b1;
                        end
                    end
                    idle_d = clk_any ? '0 : idle_q + 1'b1;
                    if (TOUT != 0 && !clk_any && idle_q == TW'(TOUT - 1)) begin
                        // Reader vanished mid-frame: park with all buttons released.
                        timeout_d = 1'b1;
                        state_d   = ST_IDLE;
                        sr_d      = '1;
                        idle_d    = '0;
                    end
                end
                ST_DONE: begin
                    if (clk_rise) begin
                        sr_d      = {sr_q[BITS-2:0], 1'b1};
                        overrun_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            sr_q         <= '1;
            bit_cnt_q    <= '0;
            idle_q       <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            idle_q       <= idle_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.joy_data   = sr_q[BITS-1];
    assign bus.frame_done = frame_done_q;
    assign bus.bit_cnt    = bit_cnt_q;
    assign bus.overrun    = overrun_q;
    assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_jtframe_db15_resp.sv
// Purpose : self-checking bench for jtframe_db15_resp acting as the DB15 reader.
// Latency : reader waits 16-cycle half periods, well beyond the 3+FILT pin latency.
// Backpr. : none; the bench paces every edge itself.
module tb_jtframe_db15_resp;
    localparam int BITS = 24;
    localparam int FILT = 2;
    localparam int TOUT = 64;
    localparam int HP   = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    jtframe_db15_resp_if #(.BITS(BITS)) bus ();

    jtframe_db15_resp #(.BITS(BITS), .FILT(FILT), .TOUT(TOUT)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int bad    = 0;
    int fd_cnt = 0;
    bit exp_q[$];
    bit obs_q[$];

    always @(negedge clk) if (bus.frame_done === 1'b1) fd_cnt++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pull load low, queue the expected frame (MSB first, active-low), release load.
    task automatic do_load(input logic [11:0] a, input logic [11:0] b);
        logic [23:0] frame;
        exp_q.delete();
        obs_q.delete();
        bus.p1       = a;
        bus.p2       = b;
        bus.joy_load = 1'b0;
        tick(12);
        frame = ~{b, a};
        for (int i = 0; i < BITS; i++) exp_q.push_back(frame[23-i]);
        bus.joy_load = 1'b1;
        tick(HP);
    endtask

    // Reader clock: sample while joy_clk is low, shift on the rising edge.
    task automatic read_bits(input int n);
        for (int i = 0; i < n; i++) begin
            bus.joy_clk = 1'b0;
            tick(HP);
            obs_q.push_back(bus.joy_data);
            bus.joy_clk = 1'b1;
            tick(HP);
        end
    endtask

    task automatic test_reset;
        int fd0;
        rst_n = 1'b0;
        tick(4);
        rst_n = 1'b1;
        fd0 = fd_cnt;
        tick(100);
        total++; if (bus.joy_data !== 1'b1) begin bad++; $display("FAIL reset_joy_data got=%b want=1", bus.joy_data); end
        total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", bus.frame_done); end
        total++; if (bus.bit_cnt !== 5'd0) begin bad++; $display("FAIL reset_bit_cnt got=%0d want=0", bus.bit_cnt); end
        total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", bus.overrun); end
        total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", bus.timeout); end
        total++; if (fd_cnt - fd0 !== 0) begin bad++; $display("FAIL reset_fd_pulses got=%0d want=0", fd_cnt - fd0); end
    endtask

    task automatic test_frame;
        int fd0;
        bit e, o;
        fd0 = fd_cnt;
        do_load(12'h001, 12'h800);
        read_bits(12);
        // Button changes mid-frame must not reach the frame in flight.
        bus.p1 = 12'hFFF;
        bus.p2 = 12'hFFF;
        read_bits(12);
        for (int i = 0; i < BITS; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL frame_bit%0d got=%b want=%b", i, o, e); end
        end
        total++; if (fd_cnt - fd0 !== 1) begin bad++; $display("FAIL frame_fd_pulses got=%0d want=1", fd_cnt - fd0); end
        total++; if (bus.bit_cnt !== 5'd24) begin bad++; $display("FAIL frame_bit_cnt got=%0d want=24", bus.bit_cnt); end
        total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL frame_overrun got=%b want=0", bus.overrun); end
    endtask

    task automatic test_overrun;
        int fd0;
        bit e, o;
        fd0 = fd_cnt;
        do_load(12'h5A3, 12'h3C6);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        read_bits(26);
        for (int i = 0; i < 26; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL ovr_bit%0d got=%b want=%b", i, o, e); end
        end
        total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b want=1", bus.overrun); end
        total++; if (bus.bit_cnt !== 5'd24) begin bad++; $display("FAIL ovr_bit_cnt got=%0d want=24", bus.bit_cnt); end
        total++; if (fd_cnt - fd0 !== 1) begin bad++; $display("FAIL ovr_fd_pulses got=%0d want=1", fd_cnt - fd0); end
        bus.joy_load = 1'b0;
        tick(12);
        total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b want=0", bus.overrun); end
        total++; if (bus.bit_cnt !== 5'd0) begin bad++; $display("FAIL ovr_load_bit_cnt got=%0d want=0", bus.bit_cnt); end
        bus.joy_load = 1'b1;
        tick(HP);
    endtask

    task automatic test_glitch;
        bit e, o;
        do_load(12'hC35, 12'h0F9);
        read_bits(5);
        for (int i = 0; i < 5; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL glitch_pre_bit%0d got=%b want=%b", i, o, e); end
        end
        bus.joy_clk = 1'b0;
        tick(1);
        bus.joy_clk = 1'b1;
        tick(HP);
        total++; if (bus.bit_cnt !== 5'd5) begin bad++; $display("FAIL glitch_bit_cnt got=%0d want=5", bus.bit_cnt); end
        total++; if (bus.joy_data !== exp_q[0]) begin bad++; $display("FAIL glitch_joy_data got=%b want=%b", bus.joy_data, exp_q[0]); end
        read_bits(3);
        for (int i = 5; i < 8; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL glitch_post_bit%0d got=%b want=%b", i, o, e); end
        end
        total++; if (bus.bit_cnt !== 5'd8) begin bad++; $display("FAIL glitch_post_cnt got=%0d want=8", bus.bit_cnt); end
    endtask

    task automatic test_timeout;
        bit e, o;
        logic [4:0] bc;
        do_load(12'h0F0, 12'h00F);
        read_bits(3);
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL tout_bit%0d got=%b want=%b", i, o, e); end
        end
        total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL tout_early got=%b want=0", bus.timeout); end
        tick(100);
        total++; if (bus.timeout !== 1'b1) begin bad++; $display("FAIL tout_flag got=%b want=1", bus.timeout); end
        total++; if (bus.joy_data !== 1'b1) begin bad++; $display("FAIL tout_joy_data got=%b want=1", bus.joy_data); end
        bc = bus.bit_cnt;
        obs_q.delete();
        read_bits(2);
        for (int i = 0; i < 2; i++) begin
            o = obs_q.pop_front();
            total++; if (o !== 1'b1) begin bad++; $display("FAIL tout_idle_bit%0d got=%b want=1", i, o); end
        end
        total++; if (bus.bit_cnt !== bc) begin bad++; $display("FAIL tout_idle_cnt got=%0d want=%0d", bus.bit_cnt, bc); end
    endtask

    task automatic test_collision;
        logic [11:0] a, b;
        logic [23:0] frame;
        bit e, o;
        do_load(12'h111, 12'h222);
        read_bits(4);
        a = 12'hA5C;
        b = 12'h3E7;
        frame = ~{b, a};
        // Load falls in the same cycle joy_clk rises.
        bus.joy_clk = 1'b0;
        tick(HP);
        bus.p1       = a;
        bus.p2       = b;
        bus.joy_load = 1'b0;
        bus.joy_clk  = 1'b1;
        tick(12);
        total++; if (bus.bit_cnt !== 5'd0) begin bad++; $display("FAIL coll_fall_cnt got=%0d want=0", bus.bit_cnt); end
        total++; if (bus.joy_data !== frame[23]) begin bad++; $display("FAIL coll_fall_data got=%b want=%b", bus.joy_data, frame[23]); end
        // Load rises in the same cycle joy_clk rises.
        bus.joy_clk = 1'b0;
        tick(HP);
        bus.joy_load = 1'b1;
        bus.joy_clk  = 1'b1;
        tick(HP);
        total++; if (bus.bit_cnt !== 5'd0) begin bad++; $display("FAIL coll_rise_cnt got=%0d want=0", bus.bit_cnt); end
        exp_q.delete();
        obs_q.delete();
        for (int i = 0; i < 10; i++) exp_q.push_back(frame[23-i]);
        read_bits(10);
        for (int i = 0; i < 10; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL coll_bit%0d got=%b want=%b", i, o, e); end
        end
        total++; if (bus.bit_cnt !== 5'd10) begin bad++; $display("FAIL coll_cnt10 got=%0d want=10", bus.bit_cnt); end
        // Reset mid-frame at bit 10.
        rst_n = 1'b0;
        tick(1);
        total++; if (bus.joy_data !== 1'b1) begin bad++; $display("FAIL rst_mid_data got=%b want=1", bus.joy_data); end
        total++; if (bus.bit_cnt !== 5'd0) begin bad++; $display("FAIL rst_mid_cnt got=%0d want=0", bus.bit_cnt); end
        rst_n = 1'b1;
        obs_q.delete();
        read_bits(2);
        for (int i = 0; i < 2; i++) begin
            o = obs_q.pop_front();
            total++; if (o !== 1'b1) begin bad++; $display("FAIL rst_tail_bit%0d got=%b want=1", i, o); end
        end
        total++; if (bus.bit_cnt !== 5'd0) begin bad++; $display("FAIL rst_tail_cnt got=%0d want=0", bus.bit_cnt); end
    endtask

    initial begin
        bus.joy_clk  = 1'b1;
        bus.joy_load = 1'b1;
        bus.p1       = '0;
        bus.p2       = '0;
        test_reset();
        test_frame();
        test_overrun();
        test_glitch();
        test_timeout();
        test_collision();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
